mem_arbiter: RTL and testbench

- Shares one external 16-bit SRAM between the instruction-fetch port and the data-memory port.
- Instruction fetch is read-only; data memory reads and writes.
- Sits between the IF/MEM stages and the board SRAM pins. Replaces the separate A/B memory ports with one arbitrated, multi-cycle access engine.
- Per-port ack signals drive pipeline stall logic.

---
 rtl/mem_arbiter.sv | 139 +++++++++++++
 tb/tb_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates IF and MEM ports onto one shared asynchronous SRAM
module mem_arbiter #(
    parameter int ADDR_W       = 16,
    parameter int DATA_W       = 16,
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ack,
    output logic [ADDR_W-1:0] sram_addr,
    output logic [DATA_W-1:0] sram_wdata,
    output logic              sram_drive,
    input  logic [DATA_W-1:0] sram_rdata,
    output logic              sram_ce_n,
    output logic              sram_oe_n,
    output logic              sram_we_n,
    output logic              busy,
    output logic              grant_dm
);
    localparam int CW = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam int SW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, RECOVER} state_t;

    state_t        state;
    state_t        nextState;
    logic [CW-1:0] cnt;
    logic [SW-1:0] starveCnt;
    logic          weReg;
    logic          anyReq;
    logic          forceIf;
    logic          pickDm;

    assign anyReq  = if_req | dm_req;
    // Fetch jumps the queue only once data has won STARVE_LIMIT times in a row against it.
    assign forceIf = if_req && dm_req && (starveCnt == SW'(STARVE_LIMIT));
    assign pickDm  = dm_req && !forceIf;

    always_ff @(posedge clk) begin
        assert (WAIT_CYCLES >= 1) else $error("mem_arbiter: WAIT_CYCLES must be >= 1");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE:    if (anyReq) nextState = ACCESS;
            ACCESS:  if (cnt == '0) nextState = RECOVER;
            RECOVER: nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt        <= '0;
            starveCnt  <= '0;
            weReg      <= 1'b0;
            grant_dm   <= 1'b0;
            sram_addr  <= '0;
            sram_wdata <= '0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        grant_dm  <= pickDm;
                        sram_addr <= pickDm ? dm_addr : if_addr;
                        weReg     <= pickDm & dm_we;
                        cnt       <= CW'(WAIT_CYCLES - 1);
                        if (pickDm) begin
                            sram_wdata <= dm_wdata;
                        end
                        if (pickDm && if_req) begin
                            starveCnt <= starveCnt + SW'(1);
                        end else begin
                            starveCnt <= '0;
                        end
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        if (!weReg) begin
                            if (grant_dm) dm_rdata <= sram_rdata;
                            else          if_rdata <= sram_rdata;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    // RECOVER keeps chip enable and write data driven so the SRAM sees its hold time.
    always_comb begin
        sram_ce_n  = 1'b1;
        sram_oe_n  = 1'b1;
        sram_we_n  = 1'b1;
        sram_drive = 1'b0;
        if_ack     = 1'b0;
        dm_ack     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            ACCESS: begin
                sram_ce_n  = 1'b0;
                sram_oe_n  = weReg;
                sram_we_n  = !weReg;
                sram_drive = weReg;
            end
            RECOVER: begin
                sram_ce_n  = 1'b0;
                sram_drive = weReg;
                if_ack     = !grant_dm;
                dm_ack     = grant_dm;
            end
            default: ;
        endcase
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - self-checking bench for mem_arbiter with SRAM model and ack scoreboard
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0;
    logic [15:0] if_addr = '0;
    logic [15:0] if_rdata;
    logic        if_ack;
    logic        dm_req = 1'b0;
    logic        dm_we = 1'b0;
    logic [15:0] dm_addr = '0;
    logic [15:0] dm_wdata = '0;
    logic [15:0] dm_rdata;
    logic        dm_ack;
    logic [15:0] sram_addr;
    logic [15:0] sram_wdata;
    logic        sram_drive;
    logic [15:0] sram_rdata = '0;
    logic        sram_ce_n, sram_oe_n, sram_we_n;
    logic        busy, grant_dm;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .WAIT_CYCLES(2), .STARVE_LIMIT(4)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
        .dm_rdata(dm_rdata), .dm_ack(dm_ack),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata), .sram_drive(sram_drive),
        .sram_rdata(sram_rdata), .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n),
        .sram_we_n(sram_we_n), .busy(busy), .grant_dm(grant_dm)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic [15:0] sramMem [logic [15:0]];
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n && sram_drive) sramMem[sram_addr] = sram_wdata;
    end
    always @(negedge clk) begin
        sram_rdata = sramMem.exists(sram_addr) ? sramMem[sram_addr] : 16'h0000;
    end

    typedef struct {
        logic [15:0] rdata;
        int          cycle;
    } exp_t;

    typedef struct {
        bit          isDm;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] expR;
    } vec_t;

    exp_t ifQ[$];
    exp_t dmQ[$];
    bit   ackLog[$];
    exp_t eIf, eDm;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (!rst && (if_ack || dm_ack)) begin
            check("ack_exclusive", {31'd0, if_ack & dm_ack}, 32'd0);
            if (if_ack) begin
                ackLog.push_back(1'b0);
                if (ifQ.size() == 0) begin
                    check("unexpected_if_ack", 32'd1, 32'd0);
                end else begin
                    eIf = ifQ.pop_front();
                    check("if_ack_grant", {31'd0, grant_dm}, 32'd0);
                    check("if_rdata", {16'd0, if_rdata}, {16'd0, eIf.rdata});
                    if (eIf.cycle >= 0) check("if_ack_cycle", cyc, eIf.cycle);
                end
            end
            if (dm_ack) begin
                ackLog.push_back(1'b1);
                if (dmQ.size() == 0) begin
                    check("unexpected_dm_ack", 32'd1, 32'd0);
                end else begin
                    eDm = dmQ.pop_front();
                    check("dm_ack_grant", {31'd0, grant_dm}, 32'd1);
                    check("dm_rdata", {16'd0, dm_rdata}, {16'd0, eDm.rdata});
                    if (eDm.cycle >= 0) check("dm_ack_cycle", cyc, eDm.cycle);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ifStart(input logic [15:0] a, input logic [15:0] expR, input int expCyc);
        if_req  = 1'b1;
        if_addr = a;
        ifQ.push_back('{expR, expCyc});
    endtask

    task automatic dmStart(input bit we, input logic [15:0] a, input logic [15:0] wd,
                           input logic [15:0] expR, input int expCyc);
        dm_req   = 1'b1;
        dm_we    = we;
        dm_addr  = a;
        dm_wdata = wd;
        dmQ.push_back('{expR, expCyc});
    endtask

    // Returns one cycle after the ack, i.e. just past the edge on which the requester may move on.
    task automatic waitAck(input bit isDm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            if (isDm ? dm_ack : if_ack) seen = 1'b1;
            else tick();
        end
        check(isDm ? "dm_ack_seen" : "if_ack_seen", {31'd0, seen}, 32'd1);
        tick();
    endtask

    task automatic checkIdleOutputs(input string tag);
        check({tag, "_ce_n"}, {31'd0, sram_ce_n}, 32'd1);
        check({tag, "_oe_n"}, {31'd0, sram_oe_n}, 32'd1);
        check({tag, "_we_n"}, {31'd0, sram_we_n}, 32'd1);
        check({tag, "_drive"}, {31'd0, sram_drive}, 32'd0);
        check({tag, "_acks"}, {30'd0, if_ack, dm_ack}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    vec_t vecs[9];
    bit   starvePat[7];
    int   c;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected finish before 200000");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{1'b1, 1'b1, 16'hFFFF, 16'h5A5A, 16'h0000};
        vecs[1] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h5A5A};
        vecs[2] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h5A5A};
        vecs[3] = '{1'b1, 1'b1, 16'h0000, 16'hC3C3, 16'h5A5A};
        vecs[4] = '{1'b0, 1'b0, 16'h0000, 16'h0000, 16'hC3C3};
        vecs[5] = '{1'b1, 1'b0, 16'h0010, 16'h0000, 16'hABCD};
        vecs[6] = '{1'b0, 1'b0, 16'h0001, 16'h0000, 16'h0000};
        vecs[7] = '{1'b1, 1'b1, 16'h0001, 16'h0F0F, 16'hABCD};
        vecs[8] = '{1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0F0F};
        starvePat = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        sramMem[16'h0010] = 16'hABCD;

        tick();
        tick();
        checkIdleOutputs("reset");
        check("reset_grant", {31'd0, grant_dm}, 32'd0);
        check("reset_addr", {16'd0, sram_addr}, 32'd0);
        check("reset_rdata", {if_rdata, dm_rdata}, 32'd0);
        rst = 1'b0;
        tick();

        // Single fetch: strobes in cycles 1-2, ack in 3, idle in 4.
        c = cyc;
        ifStart(16'h0010, 16'hABCD, c + 3);
        tick();
        check("fetch_c1_ce_oe", {30'd0, sram_ce_n, sram_oe_n}, 32'd0);
        tick();
        check("fetch_c2_ce_oe_we", {29'd0, sram_ce_n, sram_oe_n, sram_we_n}, 32'd1);
        tick();
        check("fetch_c3_ack_ce_oe", {29'd0, if_ack, sram_ce_n, sram_oe_n}, 32'b101);
        check("fetch_c3_busy", {31'd0, busy}, 32'd1);
        tick();
        if_req = 1'b0;
        check("fetch_c4_busy", {31'd0, busy}, 32'd0);

        // Data write with hold cycle, then read-back.
        c = cyc;
        dmStart(1'b1, 16'h8000, 16'h1234, 16'h0000, c + 3);
        tick();
        check("write_c1", {29'd0, sram_we_n, sram_oe_n, sram_drive}, 32'b011);
        tick();
        check("write_c2", {29'd0, sram_we_n, sram_oe_n, sram_drive}, 32'b011);
        check("write_c2_wdata", {16'd0, sram_wdata}, 32'h1234);
        tick();
        check("write_c3", {28'd0, sram_we_n, sram_drive, sram_ce_n, dm_ack}, 32'b1101);
        check("write_c3_addr", {16'd0, sram_addr}, 32'h8000);
        tick();
        check("write_c4_drive", {31'd0, sram_drive}, 32'd0);
        dmStart(1'b0, 16'h8000, 16'h0000, 16'h1234, cyc + 3);
        waitAck(1'b1);
        dm_req = 1'b0;

        // Reset in the middle of a fetch clears rdata and produces no ack.
        ifStart(16'h0010, 16'hABCD, -1);
        tick();
        rst = 1'b1;
        if_req = 1'b0;
        ifQ.delete();
        tick();
        checkIdleOutputs("rst1");
        tick();
        checkIdleOutputs("rst2");
        check("rst2_rdata", {if_rdata, dm_rdata}, 32'd0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 9; i++) begin
            if (vecs[i].isDm) begin
                dmStart(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].expR, cyc + 3);
                waitAck(1'b1);
                dm_req = 1'b0;
            end else begin
                ifStart(vecs[i].addr, vecs[i].expR, cyc + 3);
                waitAck(1'b0);
                if_req = 1'b0;
            end
        end

        // Simultaneous requests: data first, fetch at the following IDLE.
        c = cyc;
        fork
            begin
                dmStart(1'b0, 16'h8000, 16'h0000, 16'h1234, c + 3);
                waitAck(1'b1);
                dm_req = 1'b0;
            end
            begin
                ifStart(16'h0010, 16'hABCD, c + 7);
                waitAck(1'b0);
                if_req = 1'b0;
            end
        join

        // Starvation: continuous data traffic lets fetch in after four data grants.
        ackLog.delete();
        fork
            begin
                for (int k = 0; k < 6; k++) begin
                    dmStart(1'b1, 16'h9000 + 16'(k), 16'h1000 + 16'(k), 16'h1234, -1);
                    waitAck(1'b1);
                end
                dm_req = 1'b0;
            end
            begin
                ifStart(16'h0010, 16'hABCD, -1);
                waitAck(1'b0);
                if_req = 1'b0;
            end
        join
        check("starve_log_len", ackLog.size(), 32'd7);
        for (int k = 0; k < 7; k++) begin
            if (k < ackLog.size()) check("starve_order", {31'd0, ackLog[k]}, {31'd0, starvePat[k]});
        end

        // Reset during cycle 2 of a write aborts it without an ack.
        dm_req = 1'b1;
        dm_we = 1'b1;
        dm_addr = 16'h4444;
        dm_wdata = 16'h7777;
        tick();
        tick();
        rst = 1'b1;
        dm_req = 1'b0;
        tick();
        checkIdleOutputs("abort");
        check("abort_rdata", {16'd0, dm_rdata}, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        dmStart(1'b1, 16'hFFFF, 16'h9999, 16'h0000, cyc + 3);
        waitAck(1'b1);
        dm_req = 1'b0;
        dmStart(1'b0, 16'hFFFF, 16'h0000, 16'h9999, cyc + 3);
        waitAck(1'b1);
        dm_req = 1'b0;

        tick();
        tick();
        check("if_queue_drained", ifQ.size(), 32'd0);
        check("dm_queue_drained", dmQ.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
